rx_byte_fifo: RTL and testbench

//  Receive-side byte FIFO of the UART core; downstream neighbour of the byte analyser.

---
 rtl/rx_byte_fifo.sv | 164 ++++++++++++++++
 tb/tb_rx_byte_fifo.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/rx_byte_fifo.sv
// rtl/rx_byte_fifo.sv - receive-side byte FIFO with registered flags, fill level and sticky errors
//
// Buffers analysed bytes from the byte analyser for the host read port.
// Optional feature macro: RX_FIFO_ALMOST_FULL_EN (registered almost-full flag).
//
// Ports:
//   clk              system clock, rising edge
//   rst              asynchronous reset, active-high
//   n_we_i           write strobe, active-low, one byte per low cycle
//   data_i           write data, sampled when n_we_i = 0
//   p_full_o         FIFO full (count == depth), registered
//   n_re_i           read strobe, active-low, one byte per low cycle
//   data_o           read data, registered, valid the cycle after an accepted read
//   p_empty_o        FIFO empty (count == 0), registered
//   count_o          current fill level, 0..depth
//   p_clear_i        synchronous flush, active-high, overrides same-cycle read/write
//   p_overflow_o     sticky: write attempted while full and not accepted
//   p_underflow_o    sticky: read attempted while empty
//   p_almost_full_o  count >= AFULL_LEVEL (macro build only, else tied 0)

module rx_byte_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int AFULL_LEVEL = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  n_we_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  p_full_o,
    input  logic                  n_re_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  p_empty_o,
    output logic [ADDR_WIDTH:0]   count_o,
    input  logic                  p_clear_i,
    output logic                  p_overflow_o,
    output logic                  p_underflow_o,
    output logic                  p_almost_full_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic                  rd_acc;
    logic                  wr_acc;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;

    assign wr_addr = wr_ptr_q[ADDR_WIDTH-1:0];
    assign rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];

    // A flush swallows any same-cycle strobes, so acceptance is gated by it.
    // A read frees a slot this edge, which lets a write into a full FIFO.
    always_comb begin
        rd_acc = !n_re_i && !empty_q && !p_clear_i;
        wr_acc = !n_we_i && (!full_q || rd_acc) && !p_clear_i;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        data_d      = data_q;

        if (p_clear_i) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                data_d   = mem[rd_addr];
            end
            if (!n_we_i && !wr_acc) begin
                overflow_d = 1'b1;
            end
            if (!n_re_i && empty_q) begin
                underflow_d = 1'b1;
            end
        end

        // Flags come from the next pointers so they are registered yet
        // reflect the state after this edge without a strobe-to-flag path.
        count_d = wr_ptr_d - rd_ptr_d;
        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d[ADDR_WIDTH-1:0] == rd_ptr_d[ADDR_WIDTH-1:0]) &&
                  (wr_ptr_d[ADDR_WIDTH] != rd_ptr_d[ADDR_WIDTH]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            data_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            data_q      <= data_d;
        end
    end

    // Storage is not reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_addr] <= data_i;
        end
    end

`ifdef RX_FIFO_ALMOST_FULL_EN
    localparam logic [ADDR_WIDTH:0] AFULL_CNT = AFULL_LEVEL[ADDR_WIDTH:0];

    logic almost_full_q, almost_full_d;

    always_comb begin
        almost_full_d = (count_d >= AFULL_CNT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            almost_full_q <= 1'b0;
        end else begin
            almost_full_q <= almost_full_d;
        end
    end

    assign p_almost_full_o = almost_full_q;
`else
    assign p_almost_full_o = 1'b0;
`endif

    assign p_full_o      = full_q;
    assign p_empty_o     = empty_q;
    assign count_o       = count_q;
    assign p_overflow_o  = overflow_q;
    assign p_underflow_o = underflow_q;
    assign data_o        = data_q;

endmodule

// File: tb/tb_rx_byte_fifo.sv
// tb/tb_rx_byte_fifo.sv - self-checking bench for rx_byte_fifo against a queue-based model

module tb_rx_byte_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       n_we_i;
    logic [7:0] data_i;
    logic       p_full_o;
    logic       n_re_i;
    logic [7:0] data_o;
    logic       p_empty_o;
    logic [4:0] count_o;
    logic       p_clear_i;
    logic       p_overflow_o;
    logic       p_underflow_o;
    logic       p_almost_full_o;

    rx_byte_fifo dut (
        .clk             (clk),
        .rst             (rst),
        .n_we_i          (n_we_i),
        .data_i          (data_i),
        .p_full_o        (p_full_o),
        .n_re_i          (n_re_i),
        .data_o          (data_o),
        .p_empty_o       (p_empty_o),
        .count_o         (count_o),
        .p_clear_i       (p_clear_i),
        .p_overflow_o    (p_overflow_o),
        .p_underflow_o   (p_underflow_o),
        .p_almost_full_o (p_almost_full_o)
    );

    always #5 clk = ~clk;

    localparam int DEPTH = 16;
    localparam int AFULL = 12;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    logic [7:0] q[$];
    logic [7:0] data_exp;
    bit         ovf_exp;
    bit         udf_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        bit afull_exp;
`ifdef RX_FIFO_ALMOST_FULL_EN
        afull_exp = (q.size() >= AFULL);
`else
        afull_exp = 1'b0;
`endif
        chk({where, ".count"}, 32'(count_o), 32'(q.size()));
        chk({where, ".empty"}, 32'(p_empty_o), 32'(q.size() == 0));
        chk({where, ".full"}, 32'(p_full_o), 32'(q.size() == DEPTH));
        chk({where, ".data"}, 32'(data_o), 32'(data_exp));
        chk({where, ".ovf"}, 32'(p_overflow_o), 32'(ovf_exp));
        chk({where, ".udf"}, 32'(p_underflow_o), 32'(udf_exp));
        chk({where, ".afull"}, 32'(p_almost_full_o), 32'(afull_exp));
    endtask

    task automatic model_reset();
        q.delete();
        data_exp = 8'h00;
        ovf_exp  = 1'b0;
        udf_exp  = 1'b0;
    endtask

    // One clock cycle with the given strobes, then model update and full check.
    task automatic step(input bit we, input bit re, input bit clr, input logic [7:0] d,
                        input string where);
        bit rd_ok;
        bit wr_ok;
        n_we_i    = !we;
        n_re_i    = !re;
        p_clear_i = clr;
        data_i    = d;
        @(posedge clk);
        #1;
        if (clr) begin
            q.delete();
            ovf_exp = 1'b0;
            udf_exp = 1'b0;
        end else begin
            rd_ok = re && (q.size() > 0);
            wr_ok = we && ((q.size() < DEPTH) || rd_ok);
            if (re && q.size() == 0) udf_exp = 1'b1;
            if (we && !wr_ok) ovf_exp = 1'b1;
            if (rd_ok) data_exp = q.pop_front();
            if (wr_ok) q.push_back(d);
        end
        n_we_i    = 1'b1;
        n_re_i    = 1'b1;
        p_clear_i = 1'b0;
        data_i    = 8'h00;
        check_all(where);
    endtask

    initial begin
        rst       = 1'b1;
        n_we_i    = 1'b1;
        n_re_i    = 1'b1;
        p_clear_i = 1'b0;
        data_i    = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // Fill with 0x00..0x0F, then drain in order.
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 8'(i), "fill");
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 8'h00, "drain");
        step(0, 0, 0, 8'h00, "idle_empty");

        // Overflow: full FIFO drops 0xAA; oldest byte still comes out first.
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 8'(8'h40 + i), "refill");
        step(1, 0, 0, 8'hAA, "overflow");
        step(0, 1, 0, 8'h00, "read_after_ovf");
        step(1, 0, 0, 8'h77, "top_up");
        // Full with simultaneous read and write: both accepted, no new overflow.
        step(1, 1, 0, 8'h55, "full_rw");
        step(0, 0, 0, 8'h00, "ovf_sticky");
        // Flush overrides same-cycle strobes and clears sticky flags.
        step(1, 1, 1, 8'hEE, "clear");

        // Empty with simultaneous read and write: write only, underflow set.
        step(1, 1, 0, 8'h33, "empty_rw");
        step(0, 1, 0, 8'h00, "read_33");
        step(0, 1, 0, 8'h00, "underflow_again");
        step(0, 0, 1, 8'h00, "clear2");

        // Pointer wrap at steady count of 3.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 8'($urandom), "wrap_pre");
        for (int i = 0; i < 40; i++) step(1, 1, 0, 8'($urandom), "wrap");

        // Randomised traffic with varying write/read bias and rare flushes.
        for (int i = 0; i < 400; i++) begin
            int wbias;
            wbias = (i / 50) % 2 == 0 ? 75 : 30;
            step(($urandom % 100) < wbias, ($urandom % 100) < 50,
                 ($urandom % 64) == 0, 8'($urandom), "random");
        end

        // Almost-full threshold crossing.
        step(0, 0, 1, 8'h00, "clear3");
        for (int i = 0; i < AFULL; i++) step(1, 0, 0, 8'(8'h90 + i), "afull_fill");
        step(0, 1, 0, 8'h00, "afull_drop");

        // Asynchronous reset mid-traffic: outputs go to reset values without an edge.
        for (int i = 0; i < 5; i++) step(1, 0, 0, 8'(8'hC0 + i), "pre_rst");
        step(0, 1, 0, 8'h00, "pre_rst_rd");
        step(0, 1, 0, 8'h00, "pre_rst_rd2");
        n_we_i = 1'b0;
        data_i = 8'hF0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        n_we_i = 1'b1;
        check_all("rst_hold");
        rst = 1'b0;
        step(1, 0, 0, 8'h5A, "post_rst_wr");
        step(0, 1, 0, 8'h00, "post_rst_rd");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
